// File: rtl/seq_identifier.sv
`default_nettype none
// ============================================================================
// Module      : seq_identifier
// Description : Identifies which of the eight generator-bank sequences an
//               incoming byte stream follows. Eight reference models run in
//               lockstep, advancing one term per accepted sample. Each
//               candidate is eliminated on its first mismatch.
//               Optional feature macro: SEQID_AUTORESYNC_EN. When it is
//               defined, a sample that would empty the mask restarts
//               identification with that sample as term 0.
// Ports       : clk          - clock
//               reset        - synchronous active-high reset
//               restart      - pulse, starts a new identification
//               in_valid     - in_data carries a sample this cycle
//               in_data      - sample byte
//               match_mask   - bit i set = candidate i still consistent
//               match_id     - lowest set bit of match_mask (0 if none)
//               locked       - exactly one candidate remains
//               none_match   - no candidate remains
//               sample_count - accepted samples, saturating
//               resync_pulse - (SEQID_AUTORESYNC_EN only) one-cycle resync flag
// Revision    : 1.0 - initial release
// ============================================================================
module seq_identifier #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             restart,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic [7:0]       match_mask,
    output logic [2:0]       match_id,
    output logic             locked,
    output logic             none_match,
    output logic [CNT_W-1:0] sample_count
`ifdef SEQID_AUTORESYNC_EN
    ,
    output logic             resync_pulse
`endif
);

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    // Term-0 values of every model, packed ID7 (MSB) .. ID0 (LSB).
    localparam logic [63:0] c_term0 = {8'd2, 8'd1, 8'd2, 8'd0,
                                       8'd1, 8'd0, 8'd1, 8'd0};

    // Model state registers
    logic [7:0] r_sq_idx;                   // ID0 index k
    logic [7:0] r_pw3;                      // ID1 current power
    logic [7:0] r_tri, r_tri_n;             // ID2 value and index
    logic [7:0] r_fib_a, r_fib_b;           // ID3 current / next
    logic [7:0] r_pell_a, r_pell_b;         // ID4 current / next
    logic [7:0] r_luc_a, r_luc_b;           // ID5 current / next
    logic [7:0] r_pad0, r_pad1, r_pad2;     // ID6 three-term window
    logic [7:0] r_syl;                      // ID7 current term

    logic [7:0]       r_mask;
    logic [CNT_W-1:0] r_cnt;
    logic             r_resync;

    logic [7:0] w_exp [0:7];
    logic [7:0] w_hit_cur;
    logic [7:0] w_mask_upd;
    logic [7:0] w_mask_next;
    logic       w_resync;
    logic [2:0] w_id;

    // Expected term for the current position of each model
    assign w_exp[0] = r_sq_idx * r_sq_idx;
    assign w_exp[1] = r_pw3;
    assign w_exp[2] = r_tri;
    assign w_exp[3] = r_fib_a;
    assign w_exp[4] = r_pell_a;
    assign w_exp[5] = r_luc_a;
    assign w_exp[6] = r_pad0;
    assign w_exp[7] = r_syl;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_cmp
            assign w_hit_cur[gi] = (in_data == w_exp[gi]);
        end
    endgenerate

    assign w_mask_upd = r_mask & w_hit_cur;

`ifdef SEQID_AUTORESYNC_EN
    logic [7:0] w_hit_t0;

    generate
        for (genvar gj = 0; gj < 8; gj++) begin : g_cmp_t0
            assign w_hit_t0[gj] = (in_data == c_term0[8*gj +: 8]);
        end
    endgenerate

    assign w_resync    = in_valid && (w_mask_upd == 8'h00);
    assign w_mask_next = w_resync ? w_hit_t0 : w_mask_upd;
    assign resync_pulse = r_resync;
`else
    assign w_resync    = 1'b0;
    assign w_mask_next = w_mask_upd;
`endif

    // Models step from their current state, or from term 0 on a resync so
    // the resync sample is consumed as term 0 and the next one meets term 1.
    logic [7:0] w_b_sq, w_b_pw3, w_b_tri, w_b_tri_n;
    logic [7:0] w_b_fib_a, w_b_fib_b, w_b_pell_a, w_b_pell_b;
    logic [7:0] w_b_luc_a, w_b_luc_b, w_b_pad0, w_b_pad1, w_b_pad2, w_b_syl;

    assign w_b_sq     = w_resync ? 8'd0 : r_sq_idx;
    assign w_b_pw3    = w_resync ? 8'd1 : r_pw3;
    assign w_b_tri    = w_resync ? 8'd0 : r_tri;
    assign w_b_tri_n  = w_resync ? 8'd0 : r_tri_n;
    assign w_b_fib_a  = w_resync ? 8'd1 : r_fib_a;
    assign w_b_fib_b  = w_resync ? 8'd1 : r_fib_b;
    assign w_b_pell_a = w_resync ? 8'd0 : r_pell_a;
    assign w_b_pell_b = w_resync ? 8'd1 : r_pell_b;
    assign w_b_luc_a  = w_resync ? 8'd2 : r_luc_a;
    assign w_b_luc_b  = w_resync ? 8'd1 : r_luc_b;
    assign w_b_pad0   = w_resync ? 8'd1 : r_pad0;
    assign w_b_pad1   = w_resync ? 8'd1 : r_pad1;
    assign w_b_pad2   = w_resync ? 8'd1 : r_pad2;
    assign w_b_syl    = w_resync ? 8'd2 : r_syl;

    always_ff @(posedge clk) begin
        if (reset || restart) begin
            r_mask   <= 8'hFF;
            r_cnt    <= '0;
            r_resync <= 1'b0;
            r_sq_idx <= 8'd0;
            r_pw3    <= 8'd1;
            r_tri    <= 8'd0;
            r_tri_n  <= 8'd0;
            r_fib_a  <= 8'd1;
            r_fib_b  <= 8'd1;
            r_pell_a <= 8'd0;
            r_pell_b <= 8'd1;
            r_luc_a  <= 8'd2;
            r_luc_b  <= 8'd1;
            r_pad0   <= 8'd1;
            r_pad1   <= 8'd1;
            r_pad2   <= 8'd1;
            r_syl    <= 8'd2;
        end else begin
            r_resync <= w_resync;
            if (in_valid) begin
                r_mask <= w_mask_next;
                if (w_resync) begin
                    r_cnt <= c_cnt_one;
                end else if (r_cnt != c_cnt_max) begin
                    r_cnt <= r_cnt + c_cnt_one;
                end
                r_sq_idx <= w_b_sq + 8'd1;
                r_pw3    <= w_b_pw3 * 8'd3;
                r_tri    <= w_b_tri + w_b_tri_n + 8'd1;
                r_tri_n  <= w_b_tri_n + 8'd1;
                r_fib_a  <= w_b_fib_b;
                r_fib_b  <= w_b_fib_a + w_b_fib_b;
                r_pell_a <= w_b_pell_b;
                r_pell_b <= {w_b_pell_b[6:0], 1'b0} + w_b_pell_a;
                r_luc_a  <= w_b_luc_b;
                r_luc_b  <= w_b_luc_a + w_b_luc_b;
                r_pad0   <= w_b_pad1;
                r_pad1   <= w_b_pad2;
                r_pad2   <= w_b_pad0 + w_b_pad1;
                r_syl    <= (w_b_syl * (w_b_syl - 8'd1)) + 8'd1;
            end
        end
    end

    // Lowest set bit wins: scan from the top so the last hit is the lowest.
    always_comb begin
        w_id = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (r_mask[i]) begin
                w_id = i[2:0];
            end
        end
    end

    assign match_mask   = r_mask;
    assign match_id     = w_id;
    assign none_match   = (r_mask == 8'h00);
    assign locked       = (r_mask != 8'h00) && ((r_mask & (r_mask - 8'd1)) == 8'h00);
    assign sample_count = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_seq_identifier.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_identifier
// Description : Self-checking bench for seq_identifier. A table of per-cycle
//               stimulus/expected records is driven one step per clock; the
//               expected record is queued when driven and popped for
//               comparison after the clock edge. Hand-written sequences cover
//               count saturation and reset priority.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_identifier;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             restart = 1'b0;
    logic             in_valid = 1'b0;
    logic [7:0]       in_data = 8'd0;
    logic [7:0]       match_mask;
    logic [2:0]       match_id;
    logic             locked;
    logic             none_match;
    logic [CNT_W-1:0] sample_count;
`ifdef SEQID_AUTORESYNC_EN
    logic             resync_pulse;
`endif

    seq_identifier #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .restart      (restart),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .match_mask   (match_mask),
        .match_id     (match_id),
        .locked       (locked),
        .none_match   (none_match),
        .sample_count (sample_count)
`ifdef SEQID_AUTORESYNC_EN
        ,
        .resync_pulse (resync_pulse)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       rs;
        logic       v;
        logic [7:0] d;
        logic [7:0] m;
        int         c;
        logic       rp;
    } step_t;

    step_t tbl[$];
    step_t sb[$];
    int    n_pass = 0;
    int    n_total = 0;

    function automatic void add(logic rst, logic rs, logic v, logic [7:0] d,
                                logic [7:0] m, int c, logic rp);
        step_t s;
        s.rst = rst; s.rs = rs; s.v = v; s.d = d; s.m = m; s.c = c; s.rp = rp;
        tbl.push_back(s);
    endfunction

    function automatic logic [2:0] low_id(logic [7:0] m);
        logic [2:0] r;
        r = 3'd0;
        for (int b = 0; b < 8; b++) begin
            if (m[b]) begin
                r = b[2:0];
                break;
            end
        end
        return r;
    endfunction

    task automatic check(string name, int idx, int act, int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s step %0d: got %0d (0x%0h) expected %0d (0x%0h)",
                     name, idx, act, act, exp, exp);
        end
    endtask

    task automatic check_all(step_t e, int idx);
        check("mask",  idx, int'(match_mask), int'(e.m));
        check("id",    idx, int'(match_id),   int'(low_id(e.m)));
        check("locked", idx, int'(locked),    ($countones(e.m) == 1) ? 1 : 0);
        check("none",  idx, int'(none_match), (e.m == 8'h00) ? 1 : 0);
        check("count", idx, int'(sample_count), e.c);
`ifdef SEQID_AUTORESYNC_EN
        check("resync", idx, int'(resync_pulse), int'(e.rp));
`endif
    endtask

    task automatic drive(logic rst, logic rs, logic v, logic [7:0] d);
        @(negedge clk);
        reset = rst; restart = rs; in_valid = v; in_data = d;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        step_t e;

        // reset state, squares
        add(1, 0, 0, 8'd0,  8'hFF, 0, 0);
        add(0, 0, 1, 8'd0,  8'h15, 1, 0);
        add(0, 0, 1, 8'd1,  8'h15, 2, 0);
        add(0, 0, 1, 8'd4,  8'h01, 3, 0);
        add(0, 0, 1, 8'd9,  8'h01, 4, 0);
        // Fibonacci
        add(0, 1, 0, 8'd0,  8'hFF, 0, 0);
        add(0, 0, 1, 8'd1,  8'h4A, 1, 0);
        add(0, 0, 1, 8'd1,  8'h48, 2, 0);
        add(0, 0, 1, 8'd2,  8'h08, 3, 0);
        // Sylvester with mod-256 wrap
        add(0, 1, 0, 8'd0,  8'hFF, 0, 0);
        add(0, 0, 1, 8'd2,  8'hA0, 1, 0);
        add(0, 0, 1, 8'd3,  8'h80, 2, 0);
        add(0, 0, 1, 8'd7,  8'h80, 3, 0);
        add(0, 0, 1, 8'd43, 8'h80, 4, 0);
        add(0, 0, 1, 8'd15, 8'h80, 5, 0);
        // Powers of 3 with idle cycles (idle data would mismatch if sampled)
        add(0, 1, 0, 8'd0,   8'hFF, 0, 0);
        add(0, 0, 1, 8'd1,   8'h4A, 1, 0);
        add(0, 0, 0, 8'd99,  8'h4A, 1, 0);
        add(0, 0, 1, 8'd3,   8'h02, 2, 0);
        add(0, 0, 0, 8'd200, 8'h02, 2, 0);
        add(0, 0, 1, 8'd9,   8'h02, 3, 0);
        add(0, 0, 0, 8'd5,   8'h02, 3, 0);
        add(0, 0, 1, 8'd27,  8'h02, 4, 0);
        add(0, 0, 1, 8'd81,  8'h02, 5, 0);
        add(0, 0, 0, 8'd0,   8'h02, 5, 0);
        add(0, 0, 1, 8'd243, 8'h02, 6, 0);
        add(0, 0, 1, 8'd217, 8'h02, 7, 0);
`ifndef SEQID_AUTORESYNC_EN
        // elimination of the last candidate, then restart drops its sample
        add(0, 0, 1, 8'd5, 8'h00, 8, 0);
        add(0, 0, 1, 8'd0, 8'h00, 9, 0);
        add(0, 1, 1, 8'd0, 8'hFF, 0, 0);
        add(0, 0, 1, 8'd0, 8'h15, 1, 0);
        add(0, 0, 1, 8'd1, 8'h15, 2, 0);
        // reset beats restart and valid
        add(1, 1, 1, 8'd4, 8'hFF, 0, 0);
        add(0, 0, 1, 8'd1, 8'h4A, 1, 0);
`else
        // resync on a sample that empties the mask
        add(1, 0, 0, 8'd0, 8'hFF, 0, 0);
        add(0, 0, 1, 8'd0, 8'h15, 1, 0);
        add(0, 0, 1, 8'd1, 8'h15, 2, 0);
        add(0, 0, 1, 8'd7, 8'h00, 1, 1);
        add(0, 0, 0, 8'd0, 8'h00, 1, 0);
        // resync sample that matches term 0 of some models, next is term 1
        add(0, 0, 1, 8'd2, 8'hA0, 1, 1);
        add(0, 0, 1, 8'd3, 8'h80, 2, 0);
        add(1, 0, 1, 8'd7, 8'hFF, 0, 0);
`endif

        foreach (tbl[k]) begin
            drive(tbl[k].rst, tbl[k].rs, tbl[k].v, tbl[k].d);
            sb.push_back(tbl[k]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check_all(e, k);
        end

`ifndef SEQID_AUTORESYNC_EN
        // count saturation after none_match
        drive(0, 1, 0, 8'd0);
        for (int s = 0; s < 255; s++) begin
            drive(0, 0, 1, 8'hAA);
        end
        @(posedge clk); #1;
        check("sat_count_255", 1000, int'(sample_count), 255);
        check("sat_none",      1000, int'(none_match), 1);
        drive(0, 0, 1, 8'hAA);
        @(posedge clk); #1;
        check("sat_count_hold", 1001, int'(sample_count), 255);
        check("sat_mask",       1001, int'(match_mask), 0);
        drive(0, 0, 0, 8'h00);
        @(posedge clk); #1;
        check("sat_idle", 1002, int'(sample_count), 255);
`endif

        drive(0, 0, 0, 8'h00);
        @(posedge clk); #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
